// File: rtl/clint_core.sv
// Core-local interrupt controller: mtime/mtimecmp timer, software and external pending bits, req/ack bus slave.
// Optional CLINT_MTIME_SNAPSHOT_EN: a MTIME_LO read latches mtime[63:32] so a later MTIME_HI read is tear-free.
module clint_core #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned TICK_DIV   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bus_req,
    input  logic                  bus_we,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic [31:0]           bus_wdata,
    output logic [31:0]           bus_rdata,
    output logic                  bus_ack,
    input  logic                  ext_irq,
    input  logic                  external_int_clear,
    input  logic                  software_int_clear,
    input  logic                  timer_int_clear,
    output logic                  meip,
    output logic                  mtip,
    output logic                  msip
);

    localparam logic [ADDR_WIDTH-1:0] OFF_MSIP      = ADDR_WIDTH'(32'h0000);
    localparam logic [ADDR_WIDTH-1:0] OFF_MTCMP_LO  = ADDR_WIDTH'(32'h4000);
    localparam logic [ADDR_WIDTH-1:0] OFF_MTCMP_HI  = ADDR_WIDTH'(32'h4004);
    localparam logic [ADDR_WIDTH-1:0] OFF_MTIME_LO  = ADDR_WIDTH'(32'hBFF8);
    localparam logic [ADDR_WIDTH-1:0] OFF_MTIME_HI  = ADDR_WIDTH'(32'hBFFC);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK     = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [7:0]            TICK_LAST     = 8'(TICK_DIV - 1);

    logic [63:0]           mtime;
    logic [63:0]           mtimecmp;
    logic [7:0]            prescaler;
    logic                  msip_r;
    logic                  meip_r;
    logic                  tmask;
    logic                  sync1;
    logic                  sync2;
    logic                  sync3;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  tick;
    logic                  timer_hit;
    logic                  wr_en;
    logic                  wr_msip;
    logic                  wr_cmp_lo;
    logic                  wr_cmp_hi;
    logic                  wr_time_lo;
    logic                  wr_time_hi;
    logic [31:0]           read_data;
`ifdef CLINT_MTIME_SNAPSHOT_EN
    logic [31:0]           mtime_hi_shadow;
    logic                  rd_time_lo;
`endif

    assign word_addr  = bus_addr & WORD_MASK;
    assign tick       = (prescaler == TICK_LAST);
    assign timer_hit  = (mtime >= mtimecmp);
    assign wr_en      = bus_req && bus_we;
    assign wr_msip    = wr_en && (word_addr == OFF_MSIP);
    assign wr_cmp_lo  = wr_en && (word_addr == OFF_MTCMP_LO);
    assign wr_cmp_hi  = wr_en && (word_addr == OFF_MTCMP_HI);
    assign wr_time_lo = wr_en && (word_addr == OFF_MTIME_LO);
    assign wr_time_hi = wr_en && (word_addr == OFF_MTIME_HI);
`ifdef CLINT_MTIME_SNAPSHOT_EN
    assign rd_time_lo = bus_req && !bus_we && (word_addr == OFF_MTIME_LO);
`endif

    always_comb begin
        read_data = '0;
        case (word_addr)
            OFF_MSIP:     read_data = {31'd0, msip_r};
            OFF_MTCMP_LO: read_data = mtimecmp[31:0];
            OFF_MTCMP_HI: read_data = mtimecmp[63:32];
            OFF_MTIME_LO: read_data = mtime[31:0];
`ifdef CLINT_MTIME_SNAPSHOT_EN
            OFF_MTIME_HI: read_data = mtime_hi_shadow;
`else
            OFF_MTIME_HI: read_data = mtime[63:32];
`endif
            default:      read_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime     <= '0;
            prescaler <= '0;
            mtimecmp  <= '1;
            msip_r    <= 1'b0;
            meip_r    <= 1'b0;
            tmask     <= 1'b0;
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync3     <= 1'b0;
            mtip      <= 1'b0;
            bus_ack   <= 1'b0;
            bus_rdata <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 8'd1;

            // A software write to either half takes priority over the tick.
            if (wr_time_lo)
                mtime[31:0] <= bus_wdata;
            else if (wr_time_hi)
                mtime[63:32] <= bus_wdata;
            else if (tick)
                mtime <= mtime + 64'd1;

            if (wr_cmp_lo)
                mtimecmp[31:0] <= bus_wdata;
            if (wr_cmp_hi)
                mtimecmp[63:32] <= bus_wdata;

            if (wr_cmp_lo || wr_cmp_hi)
                tmask <= 1'b0;
            else if (timer_int_clear)
                tmask <= 1'b1;

            mtip <= timer_hit && !tmask;

            if (software_int_clear)
                msip_r <= 1'b0;
            else if (wr_msip)
                msip_r <= bus_wdata[0];

            sync1 <= ext_irq;
            sync2 <= sync1;
            sync3 <= sync2;
            if (external_int_clear)
                meip_r <= 1'b0;
            else if (sync2 && !sync3)
                meip_r <= 1'b1;

            bus_ack   <= bus_req;
            bus_rdata <= (bus_req && !bus_we) ? read_data : '0;
        end
    end

`ifdef CLINT_MTIME_SNAPSHOT_EN
    always_ff @(posedge clk) begin
        if (rst)
            mtime_hi_shadow <= '0;
        else if (rd_time_lo)
            mtime_hi_shadow <= mtime[63:32];
    end
`endif

    assign msip = msip_r;
    assign meip = meip_r;

endmodule

// File: tb/tb_clint_core.sv
// Scoreboard bench for clint_core: main instance with TICK_DIV=1, second instance with TICK_DIV=4.
module tb_clint_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_req, bus_we;
    logic [15:0] bus_addr;
    logic [31:0] bus_wdata, bus_rdata;
    logic        bus_ack;
    logic        ext_irq, external_int_clear, software_int_clear, timer_int_clear;
    logic        meip, mtip, msip;

    logic        req4, we4;
    logic [15:0] addr4;
    logic [31:0] wdata4, rdata4;
    logic        ack4, meip4, mtip4, msip4;
    logic        ext4, eclr4, sclr4, tclr4;

    int n_cmp = 0;
    int n_err = 0;
    int ncyc  = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];
    string       mon_tag;
    logic [31:0] mon_exp;

    clint_core #(.ADDR_WIDTH(16), .TICK_DIV(1)) dut (
        .clk(clk), .rst(rst),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .ext_irq(ext_irq), .external_int_clear(external_int_clear),
        .software_int_clear(software_int_clear), .timer_int_clear(timer_int_clear),
        .meip(meip), .mtip(mtip), .msip(msip)
    );

    clint_core #(.ADDR_WIDTH(16), .TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst),
        .bus_req(req4), .bus_we(we4), .bus_addr(addr4), .bus_wdata(wdata4),
        .bus_rdata(rdata4), .bus_ack(ack4),
        .ext_irq(ext4), .external_int_clear(eclr4),
        .software_int_clear(sclr4), .timer_int_clear(tclr4),
        .meip(meip4), .mtip(mtip4), .msip(msip4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ncyc++;
    endtask

    task automatic rd(input logic [15:0] a, input logic [31:0] exp, input string tag);
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = a; bus_wdata = '0;
        tag_q.push_back(tag);
        exp_q.push_back(exp);
        step();
        bus_req = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        tag_q.push_back("wr_rdata");
        exp_q.push_back(32'h0);
        step();
        bus_req = 1'b0; bus_we = 1'b0;
    endtask

    task automatic wr4(input logic [15:0] a, input logic [31:0] d);
        req4 = 1'b1; we4 = 1'b1; addr4 = a; wdata4 = d;
        step();
        req4 = 1'b0; we4 = 1'b0;
        check("t4_wr_ack", ack4, 1);
    endtask

    task automatic rd4(input logic [15:0] a, input logic [31:0] exp, input string tag);
        req4 = 1'b1; we4 = 1'b0; addr4 = a;
        step();
        req4 = 1'b0;
        check("t4_rd_ack", ack4, 1);
        check(tag, rdata4, exp);
    endtask

    // Scoreboard: every ack pops the next expected read value.
    always @(negedge clk) begin
        if (bus_ack) begin
            if (exp_q.size() == 0) begin
                check("ack_unexpected", 1, 0);
            end else begin
                mon_tag = tag_q.pop_front();
                mon_exp = exp_q.pop_front();
                check(mon_tag, bus_rdata, mon_exp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus_req = 0; bus_we = 0; bus_addr = '0; bus_wdata = '0;
        ext_irq = 0; external_int_clear = 0; software_int_clear = 0; timer_int_clear = 0;
        req4 = 0; we4 = 0; addr4 = '0; wdata4 = '0;
        ext4 = 0; eclr4 = 0; sclr4 = 0; tclr4 = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", bus_ack, 0);
        check("rst_rdata", bus_rdata, 0);
        check("rst_pend", {meip, mtip, msip}, 0);
        check("rst_pend4", {ack4, meip4, mtip4, msip4}, 0);
        rst = 1'b0;
        ncyc = 0;

        // Reset values and free-running mtime
        rd(16'h4000, 32'hFFFF_FFFF, "cmp_lo_rst");
        rd(16'h4004, 32'hFFFF_FFFF, "cmp_hi_rst");
        repeat (7) step();
        rd(16'hBFF8, 32'd9, "mtime_lo_10");
        rd(16'hBFFC, 32'd0, "mtime_hi_10");
        check("mtip_idle", mtip, 0);

        // Timer compare, mask, mask release
        wr(16'h4000, 32'd20);
        wr(16'h4004, 32'd0);
        while (ncyc < 20) step();
        check("mtip_before", mtip, 0);
        step();
        check("mtip_rise", mtip, 1);
        timer_int_clear = 1'b1;
        step();
        timer_int_clear = 1'b0;
        step();
        check("mtip_masked", mtip, 0);
        repeat (3) step();
        check("mtip_stay_masked", mtip, 0);
        wr(16'h4000, 32'd1000);
        check("mtip_unmask_low", mtip, 0);
        while (ncyc < 1000) step();
        check("mtip_before_1000", mtip, 0);
        step();
        check("mtip_at_1000", mtip, 1);
        rd(16'hBFF8, 32'd1001, "mtime_lo_1001");
        timer_int_clear = 1'b1;
        step();
        wr(16'h4000, 32'd5);
        check("mtip_clr_held", mtip, 0);
        timer_int_clear = 1'b0;
        step();
        check("mtip_wr_beats_clr", mtip, 1);
        rd(16'h4000, 32'd5, "cmp_lo_rdback");

        // Software pending
        wr(16'h0000, 32'hFFFF_FFFF);
        check("msip_set", msip, 1);
        rd(16'h0000, 32'd1, "msip_rd1");
        software_int_clear = 1'b1;
        wr(16'h0000, 32'd1);
        software_int_clear = 1'b0;
        check("msip_clr_wins", msip, 0);
        rd(16'h0000, 32'd0, "msip_rd0");
        wr(16'h0004, 32'd1);
        check("msip_unlisted_wr", msip, 0);

        // External pending: synchronizer latency, level hold, clear priority
        ext_irq = 1'b1;
        step(); step();
        check("meip_lat2", meip, 0);
        step();
        check("meip_lat3", meip, 1);
        external_int_clear = 1'b1;
        step();
        external_int_clear = 1'b0;
        check("meip_clr", meip, 0);
        repeat (4) step();
        check("meip_level_held", meip, 0);
        ext_irq = 1'b0;
        repeat (3) step();
        ext_irq = 1'b1;
        step(); step();
        external_int_clear = 1'b1;
        step();
        external_int_clear = 1'b0;
        check("meip_clr_beats_edge", meip, 0);
        step();
        check("meip_clr_beats_edge2", meip, 0);
        ext_irq = 1'b0;
        repeat (3) step();
        ext_irq = 1'b1;
        repeat (3) step();
        check("meip_retrigger", meip, 1);

        // 64-bit wrap
        wr(16'hBFF8, 32'hFFFF_FFFF);
        wr(16'hBFFC, 32'hFFFF_FFFF);
        rd(16'hBFF8, 32'hFFFF_FFFF, "wrap_lo_pre");
`ifdef CLINT_MTIME_SNAPSHOT_EN
        rd(16'hBFFC, 32'hFFFF_FFFF, "wrap_hi_shadow");
`else
        rd(16'hBFFC, 32'd0, "wrap_hi");
`endif
        rd(16'hBFF8, 32'd1, "wrap_lo_post");

        // Carry into the high half across a LO-then-HI read
        wr(16'hBFF8, 32'hFFFF_FFFE);
        wr(16'hBFFC, 32'd0);
        rd(16'hBFF8, 32'hFFFF_FFFE, "snap_lo");
        repeat (8) step();
`ifdef CLINT_MTIME_SNAPSHOT_EN
        rd(16'hBFFC, 32'd0, "snap_hi_shadow");
        rd(16'hBFFC, 32'd0, "snap_hi_shadow_again");
`else
        rd(16'hBFFC, 32'd1, "snap_hi_live");
`endif

        // Back-to-back requests
        rd(16'h1234, 32'd0, "unlisted_rd");
        check("b2b_ack1", bus_ack, 1);
        rd(16'h0000, 32'd0, "b2b_msip");
        check("b2b_ack2", bus_ack, 1);
        rd(16'h4004, 32'd0, "b2b_cmp_hi");
        check("b2b_ack3", bus_ack, 1);
        step();
        check("b2b_ack_end", bus_ack, 0);

        // Prescaled mtime (TICK_DIV=4)
        wr4(16'hBFF8, 32'hFFFF_FFFF);
        wr4(16'hBFFC, 32'd0);
        rd4(16'hBFFC, 32'd0, "t4_hi_pre");
        repeat (3) step();
        rd4(16'hBFFC, 32'd1, "t4_hi_carry");

        // Reset coinciding with a request
        rst = 1'b1;
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 16'h4000;
        step();
        bus_req = 1'b0;
        check("rst_req_ack", bus_ack, 0);
        check("rst_req_rdata", bus_rdata, 0);
        check("rst_req_pend", {meip, mtip, msip}, 0);
        step();
        rst = 1'b0;
        rd(16'h4000, 32'hFFFF_FFFF, "cmp_lo_rst2");
        rd(16'hBFF8, 32'd1, "mtime_lo_rst2");

        repeat (3) step();
        check("sb_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clint_core.md
Name: clint_core

Overview:
- Core-local interrupt controller. It generates the machine external, timer and software interrupt-pending lines that feed the CSR mip bits read by the trap/control unit.
- It consumes that unit's per-source clear pulses and hardware-clears the matching pending source.
- Sits on the data-memory bus as a memory-mapped slave using a simple req/ack handshake.

Parameters:
- ADDR_WIDTH, 16: width of the bus offset address (byte address within the CLINT window).
- TICK_DIV, 1: core cycles per mtime increment; legal range 1..255.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- bus_req  in  1  access request, sampled every cycle
- bus_we  in  1  1 = write, 0 = read
- bus_addr  in  ADDR_WIDTH  byte offset, word aligned (bits [1:0] ignored)
- bus_wdata  in  32  write data
- bus_rdata  out  32  read data, valid when bus_ack=1
- bus_ack  out  1  access complete
- ext_irq  in  1  asynchronous external interrupt request, level
- external_int_clear  in  1  hardware clear of external pending (from trap control)
- software_int_clear  in  1  hardware clear of software pending
- timer_int_clear  in  1  hardware clear/mask of timer pending
- meip  out  1  external interrupt pending
- mtip  out  1  timer interrupt pending
- msip  out  1  software interrupt pending

Behaviour:
- Reset (rst=1 at posedge), all values registered:
  - mtime=0, prescaler=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip_r=0, meip_r=0, tmask=0, sync flops=0.
  - bus_ack=0, bus_rdata=0, meip=0, mtip=0, msip=0.
  - A reset mid-access drops the pending ack.
- Register map (offset), unlisted offsets read 0 and ignore writes:
  - 0x0000 MSIP: bit0 = msip_r, bits[31:1] read 0.
  - 0x4000 MTIMECMP_LO; 0x4004 MTIMECMP_HI.
  - 0xBFF8 MTIME_LO; 0xBFFC MTIME_HI.
- Handshake:
  - Request sampled at posedge with bus_req=1.
  - bus_ack=1 exactly one cycle later for exactly one cycle; bus_rdata holds the read value that cycle, 0 otherwise.
  - Back-to-back requests are accepted every cycle (ack every cycle).
  - Writes take effect at the sampling edge. A read of the same register in the next request returns the new value.
- mtime:
  - Prescaler counts 0..TICK_DIV-1; mtime increments by 1 in the cycle the prescaler equals TICK_DIV-1, then the prescaler wraps to 0.
  - 64-bit wrap from all-ones to 0 with no flag.
  - A bus write to MTIME_LO/HI replaces that half and suppresses the increment in that cycle; the prescaler is not reset.
- Timer:
  - cmp = (mtime >= mtimecmp), unsigned 64-bit, evaluated on the current register values.
  - mtip is registered: mtip <= cmp && !tmask.
  - timer_int_clear=1 sets tmask.
  - Any write to MTIMECMP_LO or MTIMECMP_HI clears tmask; the write wins over a simultaneous timer_int_clear.
- Software:
  - Bus write to MSIP loads msip_r <= wdata[0].
  - software_int_clear=1 clears msip_r and wins over a simultaneous bus write.
  - msip = msip_r.
- External:
  - ext_irq passes through a 2-flop synchronizer; rising-edge detect on the synchronized value sets meip_r.
  - external_int_clear=1 clears meip_r and wins over a simultaneous edge.
  - A level held high after clear does not re-set the pending bit; a new rising edge is required.
  - meip = meip_r.
  - Latency from ext_irq rising to meip=1 is 3 cycles.
- Clear inputs are level-sensitive; holding one high for many cycles is legal and idempotent.

Optional Feature:
- Macro: CLINT_MTIME_SNAPSHOT_EN.
- Defined:
  - A read of MTIME_LO also captures mtime[63:32] into a 32-bit shadow register (reset 0) at the same edge.
  - A read of MTIME_HI returns the shadow, not live mtime, giving a tear-free 64-bit read as the sequence LO then HI.
- Undefined: no shadow; MTIME_HI reads live mtime[63:32].

Test Plan:
- Reset then read 0x4000/0x4004 -> 0xFFFFFFFF both; read 0xBFF8 at the 10th cycle after reset release with TICK_DIV=1 -> value equals cycles elapsed (±1 per the stated sampling edge); mtip=0.
- Write MTIMECMP_LO=20, HI=0 with TICK_DIV=1, mtime running -> mtip rises the cycle after mtime reaches 20. Pulse timer_int_clear -> mtip=0 next cycle and stays 0. Write MTIMECMP_LO=1000 -> mask released, mtip=0 until mtime>=1000.
- Write MSIP=1 -> msip=1 next cycle. Then assert software_int_clear and write MSIP=1 in the same cycle -> msip=0.
- ext_irq 0->1 -> meip=1 after 3 cycles. Hold ext_irq=1 and pulse external_int_clear -> meip=0 and stays 0. Toggle ext_irq 0->1 -> meip=1 again.
- Write MTIME_LO=0xFFFFFFFF, HI=0 with TICK_DIV=4 -> HI reads 1 after 4 cycles. Back-to-back req on 3 cycles -> 3 consecutive ack cycles; read 0x1234 -> rdata=0.
- CLINT_MTIME_SNAPSHOT_EN defined: mtime=0x0000_0000_FFFF_FFFE, read LO, wait 8 cycles, read HI -> HI returns 0 (snapshot), live HI=1.
